// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioning path.
package key_cond_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Synchroniser flops come up "released" so a button held through reset
  // is re-qualified from scratch.
  localparam logic SYNC_RESET_LEVEL = 1'b1;

  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-button 2-flop synchroniser plus stability counter; outputs the
// debounced pressed level (active-high).
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_key_n,
  output logic o_held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_count;
  logic          w_pressed;
  logic          w_differ;

  assign w_pressed = ~r_sync2;
  assign w_differ  = w_pressed ^ r_level;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sync1 <= SYNC_RESET_LEVEL;
      r_sync2 <= SYNC_RESET_LEVEL;
      r_level <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      // Any agreeing sample restarts the stability window.
      if (!w_differ) begin
        r_count <= '0;
      end else if (r_count == CNT_MAX) begin
        r_level <= w_pressed;
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_held = r_level;

endmodule

// File: rtl/key_conditioner.sv
// Debounces the active-low KEY buttons and emits one one-hot pulse per press,
// locked out until all buttons are released. Option: KEY_COND_CHORD_REJECT_EN.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic [KEY_WIDTH-1:0] key,
  output logic [KEY_WIDTH-1:0] key_held,
  output logic                 key_active,
  output logic                 chord_error
);

  logic [KEY_WIDTH-1:0] w_held;
  logic [KEY_WIDTH-1:0] r_held_prev;
  logic [KEY_WIDTH-1:0] w_press_edge;
  logic                 w_single;
  logic [KEY_WIDTH-1:0] r_key;
  state_t               r_state;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_deb
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .i_clock  (clock),
        .i_reset_n(reset),
        .i_key_n  (key_n[gi]),
        .o_held   (w_held[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) r_held_prev <= '0;
    else        r_held_prev <= w_held;
  end

  assign w_press_edge = w_held & ~r_held_prev;
  assign w_single     = (w_held != '0) && ((w_held & (w_held - KEY_WIDTH'(1))) == '0);

`ifdef KEY_COND_CHORD_REJECT_EN
  logic r_chord_error;
  assign chord_error = r_chord_error;
`else
  logic [KEY_WIDTH-1:0] w_lowest;
  // Two's-complement trick isolates the lowest set bit.
  assign w_lowest    = w_held & (~w_held + KEY_WIDTH'(1));
  assign chord_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_key   <= '0;
`ifdef KEY_COND_CHORD_REJECT_EN
      r_chord_error <= 1'b0;
`endif
    end else begin
      r_key <= '0;
`ifdef KEY_COND_CHORD_REJECT_EN
      r_chord_error <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_press_edge != '0) begin
            r_state <= HELD;
            if (w_single) begin
              r_key <= w_held;
            end else begin
`ifdef KEY_COND_CHORD_REJECT_EN
              r_chord_error <= 1'b1;
`else
              r_key <= w_lowest;
`endif
            end
          end
        end
        HELD: begin
          if (w_held == '0) r_state <= IDLE;
        end
      endcase
    end
  end

  assign key        = r_key;
  assign key_held   = w_held;
  assign key_active = |w_held;

endmodule

// File: tb/tb_key_conditioner.sv
// Table-driven bench for key_conditioner (DEBOUNCE_CYCLES=4) with a pulse
// scoreboard keyed on the expected cycle of each press pulse.
module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

`ifdef KEY_COND_CHORD_REJECT_EN
  localparam logic [3:0] CHORD_KEY = 4'b0000;
  localparam logic       CHORD_ERR = 1'b1;
`else
  localparam logic [3:0] CHORD_KEY = 4'b0001;
  localparam logic       CHORD_ERR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] key;
  logic [3:0] key_held;
  logic       key_active;
  logic       chord_error;

  key_conditioner #(
    .KEY_WIDTH      (4),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .key        (key),
    .key_held   (key_held),
    .key_active (key_active),
    .chord_error(chord_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  key;
    logic        chord;
  } ev_t;

  typedef struct {
    logic [3:0] kn;
    int         ncyc;
    bit         pulse;
    logic [3:0] exp_key;
    logic       exp_chord;
    logic [3:0] exp_held;
  } vec_t;

  ev_t         exp_q[$];
  vec_t        vecs[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Any nonzero key/chord_error must match the head of the scoreboard.
  ev_t e;
  always @(negedge clock) begin
    if (key !== 4'b0000 || chord_error !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d actual key=%b chord=%b required none",
                 cyc, key, chord_error);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.key !== key || e.chord !== chord_error) begin
          n_err++;
          $display("FAIL pulse actual cyc=%0d key=%b chord=%b required cyc=%0d key=%b chord=%b",
                   cyc, key, chord_error, e.cyc, e.key, e.chord);
        end else begin
          $display("pulse cyc=%0d key=%b chord=%b ok", cyc, key, chord_error);
        end
      end
    end
  end

  int unsigned c;

  initial begin
    // clean press
    vecs.push_back('{4'b1110, 20, 1'b1, 4'b0001, 1'b0, 4'b0001});
    vecs.push_back('{4'b1111, 12, 1'b0, 4'b0000, 1'b0, 4'b0000});
    // bounce on key 2
    vecs.push_back('{4'b1011, 2, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1111, 2, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1011, 2, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1111, 2, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1011, 2, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1111, 8, 1'b0, 4'b0000, 1'b0, 4'b0000});
    // hold lockout
    vecs.push_back('{4'b1101, 10, 1'b1, 4'b0010, 1'b0, 4'b0010});
    vecs.push_back('{4'b0101, 10, 1'b0, 4'b0000, 1'b0, 4'b1010});
    vecs.push_back('{4'b1111, 12, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b0111, 10, 1'b1, 4'b1000, 1'b0, 4'b1000});
    vecs.push_back('{4'b1111, 12, 1'b0, 4'b0000, 1'b0, 4'b0000});
    // chord
    vecs.push_back('{4'b1010, 12, 1'b1, CHORD_KEY, CHORD_ERR, 4'b0101});
    vecs.push_back('{4'b1111, 12, 1'b0, 4'b0000, 1'b0, 4'b0000});
    // back-to-back with 6-cycle gaps
    vecs.push_back('{4'b1110, 6, 1'b1, 4'b0001, 1'b0, 4'b0001});
    vecs.push_back('{4'b1111, 6, 1'b0, 4'b0000, 1'b0, 4'b0000});
    vecs.push_back('{4'b1110, 6, 1'b1, 4'b0001, 1'b0, 4'b0001});
    vecs.push_back('{4'b1111, 10, 1'b0, 4'b0000, 1'b0, 4'b0000});

    reset = 1'b0;
    key_n = 4'b1111;
    repeat (3) @(negedge clock);
    check("rst_key", key, 4'b0000);
    check("rst_held", key_held, 4'b0000);
    check("rst_active", {3'b000, key_active}, 4'b0000);
    check("rst_chord", {3'b000, chord_error}, 4'b0000);
    $display("reset cyc=%0d key=%b held=%b", cyc, key, key_held);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    foreach (vecs[i]) begin
      c     = cyc;
      key_n = vecs[i].kn;
      if (vecs[i].pulse) exp_q.push_back('{c + LAT, vecs[i].exp_key, vecs[i].exp_chord});
      repeat (vecs[i].ncyc) @(negedge clock);
      check("row_held", key_held, vecs[i].exp_held);
      check("row_active", {3'b000, key_active}, {3'b000, |vecs[i].exp_held});
      $display("row %0d key_n=%b cycles=%0d held=%b", i, vecs[i].kn, vecs[i].ncyc, key_held);
    end

    // reset lands on the edge that would have issued the pulse
    c     = cyc;
    key_n = 4'b1110;
    repeat (LAT - 1) @(negedge clock);
    check("pre_rst_held", key_held, 4'b0001);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_key", key, 4'b0000);
    check("midrst_held", key_held, 4'b0000);
    check("midrst_active", {3'b000, key_active}, 4'b0000);
    check("midrst_chord", {3'b000, chord_error}, 4'b0000);
    $display("mid-press reset cyc=%0d key=%b held=%b", cyc, key, key_held);
    reset = 1'b1;
    c     = cyc;
    exp_q.push_back('{c + LAT, 4'b0001, 1'b0});
    repeat (10) @(negedge clock);
    check("post_rst_held", key_held, 4'b0001);
    key_n = 4'b1111;
    repeat (10) @(negedge clock);
    check("post_rst_release", key_held, 4'b0000);
    $display("post-reset press cyc=%0d held=%b", cyc, key_held);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses actual=0 delivered required=%0d pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
